// File: rtl/echo_portal_pkg.sv
// Shared constants for the echo portal.
//   METHOD_HEARD         : method number of the single indication ("heard")
//   HDR_METHOD_W/SIZE_W  : header field widths {method, size}
//   WORD_W               : indication word width
//   ST_*                 : serializer FSM encodings
//   nw_of()              : payload words per message, ceil(data_w / 32)
package echo_portal_pkg;

  localparam logic [15:0] METHOD_HEARD = 16'd0;
  localparam int          HDR_METHOD_W = 16;
  localparam int          HDR_SIZE_W   = 16;
  localparam int          WORD_W       = 32;

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_HDR  = 2'd1;
  localparam logic [1:0]  ST_PAY  = 2'd2;

  function automatic int nw_of(input int data_w);
    return (data_w + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/echo_portal_fifo_buf.sv
// Request buffer: DEPTH-entry FIFO holding payloads waiting to be echoed.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push/din : enqueue strobe and data (ignored while not ready)
//   pop      : dequeue strobe (ignored while empty)
//   dout     : head entry
//   ready    : registered count < DEPTH, no path from pop
//   empty    : no entries
module echo_portal_fifo_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              ready,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign ready   = count < (PTR_W+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/echo_portal_fifo.sv
// Echo portal: buffers say() requests and serializes each as a "heard"
// indication message of 32-bit words (header, then payload LS word first).
// Optional feature: define ECHO_PORTAL_STATS_EN to add echo_count, the
// number of fully delivered messages (wraps at 2^32).
// Ports:
//   CLK, RST                          : clock, asynchronous active-high reset
//   RDY_request_say / EN_request_say  : request handshake, request_say_v payload
//   ind_messageSize_size(_methodNumber): message length in words per method
//   ind_indications_0_first/_deq/_notEmpty : indication word stream
//   ind_intr_status / ind_intr_channel: interrupt pending / channel id
//   RDY_ind_*                         : method-ready flags
//
// state | meaning
// IDLE  | nothing to deliver; pops FIFO head when available
// HDR   | header word presented on first
// PAY   | payload word presented; words_left counts down to last word
module echo_portal_fifo
  import echo_portal_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int INTR_CHANNEL = 0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              RDY_request_say,
  input  logic [DATA_W-1:0] request_say_v,
  input  logic              EN_request_say,
  input  logic [15:0]       ind_messageSize_size_methodNumber,
  output logic [15:0]       ind_messageSize_size,
  output logic              RDY_ind_messageSize_size,
  output logic [31:0]       ind_indications_0_first,
  output logic              RDY_ind_indications_0_first,
  input  logic              EN_ind_indications_0_deq,
  output logic              RDY_ind_indications_0_deq,
  output logic              ind_indications_0_notEmpty,
  output logic              RDY_ind_indications_0_notEmpty,
  output logic              ind_intr_status,
  output logic              RDY_ind_intr_status,
  output logic [31:0]       ind_intr_channel,
  output logic              RDY_ind_intr_channel
`ifdef ECHO_PORTAL_STATS_EN
  ,
  output logic [31:0]       echo_count
`endif
);

  localparam int NW    = nw_of(DATA_W);
  localparam int PW    = NW * WORD_W;
  localparam int CNT_W = $clog2(NW + 1);

  localparam logic [WORD_W-1:0] HDR_WORD = {METHOD_HEARD, HDR_SIZE_W'(NW + 1)};

  logic [1:0]        state;
  logic [PW-1:0]     pay_reg;
  logic [CNT_W-1:0]  words_left;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              deq;
  logic              last_deq;
  logic              not_empty;

  echo_portal_fifo_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (EN_request_say),
    .din   (request_say_v),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .ready (RDY_request_say),
    .empty (fifo_empty)
  );

  assign not_empty = state != ST_IDLE;
  assign deq       = EN_ind_indications_0_deq && not_empty;
  assign last_deq  = deq && (state == ST_PAY) && (words_left == CNT_W'(1));
  // Popping on the last-word deq lets the next message follow with no bubble.
  assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || last_deq);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      pay_reg    <= '0;
      words_left <= '0;
    end else if (fifo_pop) begin
      state      <= ST_HDR;
      pay_reg    <= PW'(fifo_dout);
      words_left <= CNT_W'(NW);
    end else if (deq) begin
      case (state)
        ST_HDR: state <= ST_PAY;
        ST_PAY: begin
          pay_reg    <= pay_reg >> WORD_W;
          words_left <= words_left - CNT_W'(1);
          if (last_deq) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ind_indications_0_first = '0;
    case (state)
      ST_HDR:  ind_indications_0_first = HDR_WORD;
      ST_PAY:  ind_indications_0_first = pay_reg[WORD_W-1:0];
      default: ind_indications_0_first = '0;
    endcase
  end

  assign ind_messageSize_size = (ind_messageSize_size_methodNumber == METHOD_HEARD)
                                ? 16'(NW + 1) : 16'd0;

  assign ind_indications_0_notEmpty     = not_empty;
  assign ind_intr_status                = not_empty;
  assign ind_intr_channel               = 32'(INTR_CHANNEL);
  assign RDY_ind_indications_0_first    = not_empty;
  assign RDY_ind_indications_0_deq      = not_empty;
  assign RDY_ind_messageSize_size       = 1'b1;
  assign RDY_ind_indications_0_notEmpty = 1'b1;
  assign RDY_ind_intr_status            = 1'b1;
  assign RDY_ind_intr_channel           = 1'b1;

`ifdef ECHO_PORTAL_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           echo_count <= '0;
    else if (last_deq) echo_count <= echo_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_echo_portal_fifo.sv
module tb_echo_portal_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  // instance a: DATA_W=32, DEPTH=4, channel 7
  logic        rdy_a, en_a, deq_a, ne_a, intr_a;
  logic        rdy_msize_a, rdy_first_a, rdy_deq_a, rdy_ne_a, rdy_intr_a, rdy_chan_a;
  logic [31:0] v_a, first_a, chan_a;
  logic [15:0] mnum_a, msize_a;
  // instance b: DATA_W=72, DEPTH=4, channel 3
  logic        rdy_b, en_b, deq_b, ne_b, intr_b;
  logic        rdy_msize_b, rdy_first_b, rdy_deq_b, rdy_ne_b, rdy_intr_b, rdy_chan_b;
  logic [71:0] v_b;
  logic [31:0] first_b, chan_b;
  logic [15:0] mnum_b, msize_b;
`ifdef ECHO_PORTAL_STATS_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  echo_portal_fifo #(.DATA_W(32), .DEPTH(4), .INTR_CHANNEL(7)) dut_a (
    .CLK(clk), .RST(rst),
    .RDY_request_say(rdy_a), .request_say_v(v_a), .EN_request_say(en_a),
    .ind_messageSize_size_methodNumber(mnum_a), .ind_messageSize_size(msize_a),
    .RDY_ind_messageSize_size(rdy_msize_a),
    .ind_indications_0_first(first_a), .RDY_ind_indications_0_first(rdy_first_a),
    .EN_ind_indications_0_deq(deq_a), .RDY_ind_indications_0_deq(rdy_deq_a),
    .ind_indications_0_notEmpty(ne_a), .RDY_ind_indications_0_notEmpty(rdy_ne_a),
    .ind_intr_status(intr_a), .RDY_ind_intr_status(rdy_intr_a),
    .ind_intr_channel(chan_a), .RDY_ind_intr_channel(rdy_chan_a)
`ifdef ECHO_PORTAL_STATS_EN
    , .echo_count(cnt_a)
`endif
  );

  echo_portal_fifo #(.DATA_W(72), .DEPTH(4), .INTR_CHANNEL(3)) dut_b (
    .CLK(clk), .RST(rst),
    .RDY_request_say(rdy_b), .request_say_v(v_b), .EN_request_say(en_b),
    .ind_messageSize_size_methodNumber(mnum_b), .ind_messageSize_size(msize_b),
    .RDY_ind_messageSize_size(rdy_msize_b),
    .ind_indications_0_first(first_b), .RDY_ind_indications_0_first(rdy_first_b),
    .EN_ind_indications_0_deq(deq_b), .RDY_ind_indications_0_deq(rdy_deq_b),
    .ind_indications_0_notEmpty(ne_b), .RDY_ind_indications_0_notEmpty(rdy_ne_b),
    .ind_intr_status(intr_b), .RDY_ind_intr_status(rdy_intr_b),
    .ind_intr_channel(chan_b), .RDY_ind_intr_channel(rdy_chan_b)
`ifdef ECHO_PORTAL_STATS_EN
    , .echo_count(cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] v);
    qa.push_back(32'h0000_0002);
    qa.push_back(v);
  endtask

  task automatic wait_ne_a(input int budget);
    for (int i = 0; i < budget && !ne_a; i++) tick();
    chk("wait_ne_a", 32'(ne_a), 32'd1);
  endtask

  task automatic drain_a(input int budget);
    deq_a = 1'b1;
    for (int i = 0; i < budget && qa.size() > 0; i++) begin
      if (ne_a) chk("drain_a_word", first_a, qa.pop_front());
      tick();
    end
    deq_a = 1'b0;
    chk("drain_a_left", 32'(qa.size()), 32'd0);
    chk("drain_a_idle", 32'(ne_a), 32'd0);
  endtask

  task automatic drain_b(input int budget);
    deq_b = 1'b1;
    for (int i = 0; i < budget && qb.size() > 0; i++) begin
      if (ne_b) chk("drain_b_word", first_b, qb.pop_front());
      tick();
    end
    deq_b = 1'b0;
    chk("drain_b_left", 32'(qb.size()), 32'd0);
    chk("drain_b_idle", 32'(ne_b), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; deq_a = 1'b0; v_a = '0; mnum_a = 16'd0;
    en_b = 1'b0; deq_b = 1'b0; v_b = '0; mnum_b = 16'd0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_rdy",   32'(rdy_a),   32'd1);
    chk("rst_ne",    32'(ne_a),    32'd0);
    chk("rst_first", first_a,      32'd0);
    chk("rst_intr",  32'(intr_a),  32'd0);
    rst = 1'b0;
    tick();
    chk("chan_a",        chan_a,          32'd7);
    chk("chan_b",        chan_b,          32'd3);
    chk("msize_a_m0",    32'(msize_a),    32'd2);
    chk("msize_b_m0",    32'(msize_b),    32'd4);
    mnum_a = 16'd5; mnum_b = 16'd5;
    #1;
    chk("msize_a_m5",    32'(msize_a),    32'd0);
    chk("msize_b_m5",    32'(msize_b),    32'd0);
    mnum_a = 16'd0; mnum_b = 16'd0;
    chk("rdy_msize",     32'(rdy_msize_a), 32'd1);
    chk("rdy_first_idle",32'(rdy_first_a), 32'd0);
    chk("rdy_deq_idle",  32'(rdy_deq_a),   32'd0);
    chk("rdy_ne_const",  32'(rdy_ne_a),    32'd1);
    chk("rdy_intr_const",32'(rdy_intr_a),  32'd1);
    chk("rdy_chan_const",32'(rdy_chan_a),  32'd1);
`ifdef ECHO_PORTAL_STATS_EN
    chk("cnt_rst", cnt_a, 32'd0);
`endif

    // single echo with latency check
    v_a = 32'hDEAD_BEEF; en_a = 1'b1; push_a(v_a);
    tick();
    en_a = 1'b0;
    chk("lat_t1_ne", 32'(ne_a), 32'd0);
    tick();
    chk("lat_t2_ne",   32'(ne_a),        32'd1);
    chk("lat_t2_intr", 32'(intr_a),      32'd1);
    chk("lat_t2_rdyf", 32'(rdy_first_a), 32'd1);
    chk("single_hdr",  first_a, qa.pop_front());
    deq_a = 1'b1;
    tick();
    chk("single_pay",  first_a, qa.pop_front());
    chk("single_intr", 32'(intr_a), 32'd1);
    tick();
    deq_a = 1'b0;
    chk("single_done_ne",   32'(ne_a),   32'd0);
    chk("single_done_intr", 32'(intr_a), 32'd0);

    // wide payload
    v_b = 72'hAB_1122_3344_5566_7788; en_b = 1'b1;
    qb.push_back(32'h0000_0004); qb.push_back(32'h5566_7788);
    qb.push_back(32'h1122_3344); qb.push_back(32'h0000_00AB);
    tick();
    en_b = 1'b0;
    drain_b(20);
`ifdef ECHO_PORTAL_STATS_EN
    chk("cnt_b", cnt_b, 32'd1);
`endif

    // full: 4 buffered + 1 in serializer, 6th refused
    deq_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("full_rdy", 32'(rdy_a), (i < 5) ? 32'd1 : 32'd0);
      v_a = 32'hA000_0000 + 32'(i); en_a = 1'b1;
      if (i < 5) push_a(v_a);
      tick();
    end
    repeat (2) begin
      chk("full_hold_rdy", 32'(rdy_a), 32'd0);
      tick();
    end
    en_a = 1'b0;
    chk("full_ne",  32'(ne_a), 32'd1);
    chk("full_hdr", first_a, qa[0]);
    deq_a = 1'b1;
    chk("full_d0", first_a, qa.pop_front());
    tick();
    chk("full_d1", first_a, qa.pop_front());
    tick();
    deq_a = 1'b0;
    chk("full_rdy_after", 32'(rdy_a), 32'd1);
    v_a = 32'hA000_0005; en_a = 1'b1; push_a(v_a);
    tick();
    en_a = 1'b0;
    drain_a(60);

    // back-to-back
    for (int i = 0; i < 3; i++) begin
      v_a = 32'hB000_0000 + 32'(i); en_a = 1'b1; push_a(v_a);
      tick();
    end
    en_a = 1'b0;
    repeat (4) tick();
    deq_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("b2b_ne",   32'(ne_a), 32'd1);
      chk("b2b_word", first_a, qa.pop_front());
      tick();
    end
    deq_a = 1'b0;
    chk("b2b_idle", 32'(ne_a), 32'd0);
`ifdef ECHO_PORTAL_STATS_EN
    chk("cnt_a_total", cnt_a, 32'd10);
`endif

    // reset mid-message
    v_a = 32'hC000_0001; en_a = 1'b1; push_a(v_a);
    tick();
    en_a = 1'b0;
    wait_ne_a(10);
    deq_a = 1'b1;
    chk("mid_hdr", first_a, qa.pop_front());
    tick();
    deq_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ne",    32'(ne_a),   32'd0);
    chk("mid_rst_rdy",   32'(rdy_a),  32'd1);
    chk("mid_rst_first", first_a,     32'd0);
    chk("mid_rst_intr",  32'(intr_a), 32'd0);
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_no_resend", 32'(ne_a), 32'd0);
    v_a = 32'hD000_0002; en_a = 1'b1; push_a(v_a);
    tick();
    en_a = 1'b0;
    wait_ne_a(10);
    drain_a(20);
`ifdef ECHO_PORTAL_STATS_EN
    chk("cnt_a_after_rst", cnt_a, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_portal_fifo.md
ECHO_PORTAL_FIFO -- requirements
Module: echo_portal_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, echoed payload width (1..128).
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of 2, 2..64).
REQ-003 SHALL have parameter INTR_CHANNEL, default 0, value driven on ind_intr_channel.
REQ-004 SHALL have CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have RDY_request_say  output  1  request FIFO not full.
REQ-007 SHALL have request_say_v  input  DATA_W  payload to echo.
REQ-008 SHALL have EN_request_say  input  1  enqueue strobe.
REQ-009 SHALL have ind_messageSize_size_methodNumber  input  16  method queried.
REQ-010 SHALL have ind_messageSize_size  output  16  message length in 32-bit words.
REQ-011 SHALL have ind_indications_0_first  output  32  current indication word.
REQ-012 SHALL have EN_ind_indications_0_deq  input  1  consume current word.
REQ-013 SHALL have ind_indications_0_notEmpty  output  1  word valid.
REQ-014 SHALL have ind_intr_status, 1, and ind_intr_channel, 32, outputs  interrupt pending / channel.
REQ-015 SHALL drive every RDY_ind_* output constant 1 except RDY_ind_indications_0_first and RDY_ind_indications_0_deq, which equal notEmpty.

Function
REQ-016 SHALL enqueue request_say_v when EN_request_say && RDY_request_say; EN while not ready is ignored.
REQ-017 SHALL define NW = ceil(DATA_W/32); each message = 1 header word + NW payload words.
REQ-018 SHALL return NW+1 on ind_messageSize_size for methodNumber 0 (heard), 0 otherwise, combinationally.
REQ-019 SHALL format header as {16'h0000 method 0, 16-bit NW+1}; payload words least-significant first, last word zero-extended.
REQ-020 SHALL run serializer FSM IDLE -> HDR -> PAY -> (HDR if FIFO non-empty else IDLE).
REQ-021 SHALL in IDLE pop FIFO head into payload register when non-empty, entering HDR next cycle.
REQ-022 SHALL in HDR/PAY assert notEmpty; each deq advances one word; deq on last payload word pops next entry in the same cycle if available (back-to-back messages, no bubble).
REQ-023 SHALL ignore EN_ind_indications_0_deq when notEmpty is 0.
REQ-024 SHALL give latency: request accepted cycle t -> header on first at t+2 when idle.
REQ-025 SHALL allow enqueue and serializer pop in the same cycle; RDY_request_say stays 1 when FIFO is full but popped that cycle only if registered count < DEPTH (no combinational pop-to-ready path).
REQ-026 SHALL set ind_intr_status = notEmpty; ind_intr_channel = INTR_CHANNEL.
REQ-027 SHALL keep FIFO pointers log2(DEPTH) bits wrapping modulo DEPTH, count log2(DEPTH)+1 bits.

Reset
REQ-028 SHALL on RST clear FIFO (count 0), FSM to IDLE, word index 0; outputs: RDY_request_say 1, notEmpty 0, first 0, intr_status 0.
REQ-029 SHALL discard any partially delivered message when RST asserts mid-operation; no words resent after release.

Configuration
REQ-030 SHALL, with ECHO_PORTAL_STATS_EN defined, add output echo_count  32  count of fully delivered messages, incremented on last-word deq, wrapping at 2^32, reset 0; without it the port and counter are absent.

Structure
REQ-031 SHALL place method number constant, header layout widths and NW computation function in shared package echo_portal_pkg.
REQ-032 SHALL implement the request buffer as sub-module echo_portal_fifo_buf (parametrised DATA_W, DEPTH).

Verification
REQ-033 SHALL cover single echo: DATA_W=32, say 0xDEADBEEF -> words 0x00000002, 0xDEADBEEF; intr_status high cycles t+2 until second deq.
REQ-034 SHALL cover wide payload: DATA_W=72, say 0xAB_11223344_55667788 -> 0x00000004, 0x55667788, 0x11223344, 0x000000AB.
REQ-035 SHALL cover full: DEPTH=4, deq held 0, 6 says -> RDY_request_say low after 5th accepted (4 buffered + 1 in serializer), 6th ignored until first message drains.
REQ-036 SHALL cover back-to-back: 3 queued says, deq held 1 -> 6 consecutive valid words with no notEmpty gap.
REQ-037 SHALL cover reset mid-message: RST after header deq -> notEmpty 0, RDY 1, next say yields fresh header.
REQ-038 SHALL cover messageSize: methodNumber 0 -> NW+1, methodNumber 5 -> 0; with ECHO_PORTAL_STATS_EN echo_count equals messages delivered.
